// File: rtl/rect_blitter_if.sv
// Request/pixel bundle between the movement datapath, rect_blitter and vga_adapter.
// master drives rectangle requests; slave (the blitter) returns status and the pixel stream.
interface rect_blitter_if #(
    parameter int COLOUR_BITS = 24
);
    logic                   start;
    logic                   abort;
    logic [7:0]             x0;
    logic [6:0]             y0;
    logic [7:0]             w;
    logic [6:0]             h;
    logic [COLOUR_BITS-1:0] colour_in;
    logic                   busy;
    logic                   done;
    logic [7:0]             x_out;
    logic [6:0]             y_out;
    logic [COLOUR_BITS-1:0] colour_out;
    logic                   plot;

    modport master (
        output start, abort, x0, y0, w, h, colour_in,
        input  busy, done, x_out, y_out, colour_out, plot
    );

    modport slave (
        input  start, abort, x0, y0, w, h, colour_in,
        output busy, done, x_out, y_out, colour_out, plot
    );
endinterface

// File: rtl/rect_blitter.sv
// Clipped rectangle fill: latches a request, then streams one pixel per clock in raster
// order to vga_adapter and pulses done when the last pixel has been presented.
module rect_blitter #(
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int COLOUR_BITS = 24
) (
    input  logic          clk,
    input  logic          resetn,
    rect_blitter_if.slave blit
);

    localparam logic [8:0] LP_W9 = 9'(SCREEN_W);
    localparam logic [7:0] LP_W8 = 8'(SCREEN_W);
    localparam logic [8:0] LP_H9 = 9'(SCREEN_H);
    localparam logic [6:0] LP_H7 = 7'(SCREEN_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_DRAW  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [7:0]             r_x0;
    logic [6:0]             r_y0;
    logic [7:0]             r_w;
    logic [6:0]             r_h;
    logic [COLOUR_BITS-1:0] r_colour;
    logic [7:0]             r_xe;
    logic [6:0]             r_ye;
    logic [7:0]             r_cx;
    logic [6:0]             r_cy;

    logic                   r_busy;
    logic                   r_done;
    logic                   r_plot;
    logic [7:0]             r_x_out;
    logic [6:0]             r_y_out;
    logic [COLOUR_BITS-1:0] r_colour_out;

    logic [8:0]             w_xe_sum;
    logic [8:0]             w_ye_sum;
    logic [7:0]             w_xe;
    logic [6:0]             w_ye;
    logic                   w_empty;
    logic [7:0]             w_cx_inc;
    logic [6:0]             w_cy_inc;
    logic                   w_row_end;
    logic                   w_last;

    // Clipping, emptiness and cursor-advance arithmetic (9-bit sums cannot wrap)
    always_comb begin
        w_xe_sum = {1'b0, r_x0} + {1'b0, r_w};
        w_ye_sum = {2'b00, r_y0} + {2'b00, r_h};
        if (w_xe_sum > LP_W9) begin
            w_xe = LP_W8;
        end else begin
            w_xe = w_xe_sum[7:0];
        end
        if (w_ye_sum > LP_H9) begin
            w_ye = LP_H7;
        end else begin
            w_ye = w_ye_sum[6:0];
        end
        w_empty   = (r_w == 8'd0) || (r_h == 7'd0) ||
                    ({1'b0, r_x0} >= LP_W9) || ({2'b00, r_y0} >= LP_H9);
        w_cx_inc  = r_cx + 8'd1;
        w_cy_inc  = r_cy + 7'd1;
        w_row_end = (w_cx_inc == r_xe);
        w_last    = w_row_end && (w_cy_inc == r_ye);
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort only matters while setting up or drawing
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (blit.start) begin
                    w_state_nxt = S_SETUP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETUP: begin
                if (blit.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_empty) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_state_nxt = S_DRAW;
                end
            end
            S_DRAW: begin
                if (blit.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_state_nxt = S_DRAW;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request latch, cursor and registered pixel outputs; the output registers are loaded
    // on the edge that enters each pixel so x_out/y_out always equal the live cursor in DRAW
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x0         <= 8'd0;
            r_y0         <= 7'd0;
            r_w          <= 8'd0;
            r_h          <= 7'd0;
            r_colour     <= '0;
            r_xe         <= 8'd0;
            r_ye         <= 7'd0;
            r_cx         <= 8'd0;
            r_cy         <= 7'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_plot       <= 1'b0;
            r_x_out      <= 8'd0;
            r_y_out      <= 7'd0;
            r_colour_out <= '0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_plot <= 1'b0;
                    if (blit.start) begin
                        r_x0     <= blit.x0;
                        r_y0     <= blit.y0;
                        r_w      <= blit.w;
                        r_h      <= blit.h;
                        r_colour <= blit.colour_in;
                    end
                end
                S_SETUP: begin
                    if (blit.abort) begin
                        r_plot <= 1'b0;
                        r_done <= 1'b0;
                    end else if (w_empty) begin
                        r_plot <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_xe         <= w_xe;
                        r_ye         <= w_ye;
                        r_cx         <= r_x0;
                        r_cy         <= r_y0;
                        r_x_out      <= r_x0;
                        r_y_out      <= r_y0;
                        r_colour_out <= r_colour;
                        r_plot       <= 1'b1;
                        r_done       <= 1'b0;
                    end
                end
                S_DRAW: begin
                    if (blit.abort) begin
                        r_plot <= 1'b0;
                        r_done <= 1'b0;
                    end else if (w_last) begin
                        r_plot <= 1'b0;
                        r_done <= 1'b1;
                    end else if (w_row_end) begin
                        r_cx    <= r_x0;
                        r_cy    <= w_cy_inc;
                        r_x_out <= r_x0;
                        r_y_out <= w_cy_inc;
                        r_plot  <= 1'b1;
                    end else begin
                        r_cx    <= w_cx_inc;
                        r_x_out <= w_cx_inc;
                        r_plot  <= 1'b1;
                    end
                end
                S_FIN: begin
                    r_done <= 1'b0;
                    r_plot <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                    r_plot <= 1'b0;
                end
            endcase
        end
    end

    assign blit.busy       = r_busy;
    assign blit.done       = r_done;
    assign blit.plot       = r_plot;
    assign blit.x_out      = r_x_out;
    assign blit.y_out      = r_y_out;
    assign blit.colour_out = r_colour_out;

endmodule

// File: tb/tb_rect_blitter.sv
// Directed bench for rect_blitter: raster order, clipping, empty requests, ignored restart,
// abort and asynchronous reset, all against hand-computed pixel sequences.
module tb_rect_blitter;

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_err;
    int   exp_last_x;
    int   exp_last_y;

    rect_blitter_if #(.COLOUR_BITS(24)) bus ();

    rect_blitter #(
        .SCREEN_W   (160),
        .SCREEN_H   (120),
        .COLOUR_BITS(24)
    ) u_dut (
        .clk   (clk),
        .resetn(resetn),
        .blit  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Present one request for one clock; scramble the inputs afterwards to prove latching
    task automatic start_rect(input logic [7:0] x, input logic [6:0] y, input logic [7:0] ww,
                              input logic [6:0] hh, input logic [23:0] col, input logic ab);
        @(negedge clk);
        bus.x0 = x; bus.y0 = y; bus.w = ww; bus.h = hh; bus.colour_in = col;
        bus.start = 1'b1; bus.abort = ab;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.x0 = 8'hAA; bus.y0 = 7'h55; bus.w = 8'h01; bus.h = 7'h01; bus.colour_in = 24'h5A5A5A;
    endtask

    // Called in the SETUP cycle; checks wc*hc back-to-back pixels, then done, then idle
    task automatic expect_draw(input int ex, input int ey, input logic [23:0] col,
                               input int wc, input int hc, input int restart_at);
        chk("setup_busy", bus.busy, 32'd1);
        chk("setup_plot", bus.plot, 32'd0);
        chk("setup_done", bus.done, 32'd0);
        for (int k = 0; k < wc * hc; k++) begin
            @(negedge clk);
            chk("plot", bus.plot, 32'd1);
            chk("x", bus.x_out, 32'(ex + k % wc));
            chk("y", bus.y_out, 32'(ey + k / wc));
            chk("colour", bus.colour_out, col);
            chk("busy", bus.busy, 32'd1);
            chk("done_early", bus.done, 32'd0);
            exp_last_x = ex + k % wc;
            exp_last_y = ey + k / wc;
            bus.start = (k == restart_at);
            if (k == restart_at) begin
                bus.x0 = 8'd100; bus.y0 = 7'd100; bus.w = 8'd2; bus.h = 7'd2;
                bus.colour_in = 24'hABCDEF;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk("done", bus.done, 32'd1);
        chk("done_plot", bus.plot, 32'd0);
        chk("done_busy", bus.busy, 32'd1);
        chk("hold_x", bus.x_out, 32'(exp_last_x));
        chk("hold_y", bus.y_out, 32'(exp_last_y));
        @(negedge clk);
        chk("after_done", bus.done, 32'd0);
        chk("after_busy", bus.busy, 32'd0);
        chk("after_plot", bus.plot, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_err = 0; exp_last_x = 0; exp_last_y = 0;
        resetn = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.x0 = 8'd0; bus.y0 = 7'd0; bus.w = 8'd0; bus.h = 7'd0; bus.colour_in = 24'd0;

        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 32'd0);
        chk("rst_done", bus.done, 32'd0);
        chk("rst_plot", bus.plot, 32'd0);
        chk("rst_x", bus.x_out, 32'd0);
        chk("rst_colour", bus.colour_out, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_busy", bus.busy, 32'd0);

        // 3x2 at (10,20): six plots, busy for 8 cycles
        start_rect(8'd10, 7'd20, 8'd3, 7'd2, 24'hFF0000, 1'b0);
        expect_draw(10, 20, 24'hFF0000, 3, 2, -1);

        // Corner clip: 4x3 at (158,119) leaves (158,119),(159,119)
        start_rect(8'd158, 7'd119, 8'd4, 7'd3, 24'h00FF00, 1'b0);
        expect_draw(158, 119, 24'h00FF00, 2, 1, -1);

        // w=0: no plot, done 2 cycles after start, outputs hold (159,119)
        start_rect(8'd50, 7'd50, 8'd0, 7'd5, 24'h0000FF, 1'b0);
        expect_draw(50, 50, 24'h0000FF, 0, 0, -1);

        // Origin just off-screen: empty
        start_rect(8'd160, 7'd0, 8'd5, 7'd5, 24'h111111, 1'b0);
        expect_draw(160, 0, 24'h111111, 0, 0, -1);

        // Exact fit against the right edge: 3x2 at (157,118)
        start_rect(8'd157, 7'd118, 8'd3, 7'd2, 24'h222222, 1'b0);
        expect_draw(157, 118, 24'h222222, 3, 2, -1);

        // 16x16 at (0,0) with a second start at plot 5 that must be ignored
        start_rect(8'd0, 7'd0, 8'd16, 7'd16, 24'h0000FF, 1'b0);
        expect_draw(0, 0, 24'h0000FF, 16, 16, 4);
        repeat (3) begin
            @(negedge clk);
            chk("no_queued_start", bus.busy, 32'd0);
        end

        // start and abort together in IDLE: start wins
        start_rect(8'd7, 7'd8, 8'd1, 7'd1, 24'h333333, 1'b1);
        expect_draw(7, 8, 24'h333333, 1, 1, -1);

        // 8x8 at (20,30), abort at plot 10
        start_rect(8'd20, 7'd30, 8'd8, 7'd8, 24'h123456, 1'b0);
        chk("abort_setup_busy", bus.busy, 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("abort_plot", bus.plot, 32'd1);
            chk("abort_x", bus.x_out, 32'(20 + k % 8));
            chk("abort_y", bus.y_out, 32'(30 + k / 8));
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("aborted_plot", bus.plot, 32'd0);
        chk("aborted_busy", bus.busy, 32'd0);
        chk("aborted_done", bus.done, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("aborted_no_done", bus.done, 32'd0);
        end
        exp_last_x = 21; exp_last_y = 31;
        start_rect(8'd5, 7'd5, 8'd1, 7'd1, 24'h444444, 1'b0);
        expect_draw(5, 5, 24'h444444, 1, 1, -1);

        // Full screen, asynchronous reset at plot 1000
        start_rect(8'd0, 7'd0, 8'd160, 7'd120, 24'h777777, 1'b0);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            chk("full_plot", bus.plot, 32'd1);
            chk("full_x", bus.x_out, 32'(k % 160));
            chk("full_y", bus.y_out, 32'(k / 160));
        end
        #2 resetn = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 32'd0);
        chk("arst_done", bus.done, 32'd0);
        chk("arst_plot", bus.plot, 32'd0);
        chk("arst_x", bus.x_out, 32'd0);
        chk("arst_y", bus.y_out, 32'd0);
        chk("arst_colour", bus.colour_out, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", bus.busy, 32'd0);
        chk("post_rst_done", bus.done, 32'd0);
        exp_last_x = 0; exp_last_y = 0;
        start_rect(8'd0, 7'd0, 8'd2, 7'd1, 24'h888888, 1'b0);
        expect_draw(0, 0, 24'h888888, 2, 1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
